// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream in, word writes out.
// Holds the CPU in reset until a full image has been written.
module imem_loader #(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_wEn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_nx;
    logic [15:0] len_q;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;

    logic              xfer;
    logic [15:0]       len_full;
    logic [15:0]       word_nx;
    logic              too_long;
    logic [ADDR_W-1:0] word_addr;

    assign xfer      = in_valid && in_ready;
    assign len_full  = {in_data, len_q[7:0]};
    assign word_nx   = word_idx + 16'd1;
    assign too_long  = {1'b0, len_full} > MAX_W;
    assign word_addr = ADDR_W'({word_idx, 2'b00});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) state_nx = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) begin
                    if (len_full == 16'd0) state_nx = DONE;
                    else if (too_long)     state_nx = IDLE;
                    else                   state_nx = DATA;
                end
            end
            DATA: begin
                if (xfer && byte_idx == 2'd3) state_nx = WRITE;
            end
            WRITE: begin
                state_nx = (word_nx == len_q) ? DONE : DATA;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and status decode purely from the state register.
    always_comb begin
        in_ready = 1'b0;
        mem_wEn  = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        unique case (1'b1)
            (state == LEN_LO),
            (state == LEN_HI),
            (state == DATA):  in_ready = 1'b1;
            (state == WRITE): mem_wEn  = 1'b1;
            (state == DONE):  done     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q          <= '0;
            word_idx       <= '0;
            byte_idx       <= '0;
            asm_q          <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            cpu_hold       <= 1'b1;
            error          <= 1'b0;
            word_count     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        word_count <= '0;
                        byte_idx   <= '0;
                        word_idx   <= '0;
                        cpu_hold   <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (xfer) len_q[7:0] <= in_data;
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= in_data;
                        if (too_long) error <= 1'b1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: asm_q[7:0]   <= in_data;
                            2'd1: asm_q[15:8]  <= in_data;
                            2'd2: asm_q[23:16] <= in_data;
                            default: begin
                                mem_write_data <= {in_data, asm_q};
                                mem_address    <= word_addr;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_idx   <= word_nx;
                    word_count <= word_count + 16'd1;
                end
                DONE: begin
                    cpu_hold <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; a negedge monitor scores memory
// writes against a queue of expected {address, data} pairs.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_wEn;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    imem_loader #(.ADDR_W(16), .MAX_WORDS(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mem_wEn(mem_wEn),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .error(error),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [47:0] sb[$];
    int checks = 0;
    int errors = 0;
    int mchecks = 0;
    int merrs = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        logic [47:0] exp_w;
        if (rst === 1'b1) begin
            if (done === 1'b1) done_cnt++;
            if (mem_wEn === 1'b1) begin
                mchecks++;
                if (in_ready !== 1'b0) begin
                    merrs++;
                    $display("FAIL ready_in_write act=%b exp=0", in_ready);
                end
                mchecks++;
                if (sb.size() == 0) begin
                    merrs++;
                    $display("FAIL unexpected_write act=%h:%h exp=none",
                             mem_address, mem_write_data);
                end else begin
                    exp_w = sb.pop_front();
                    if ({mem_address, mem_write_data} !== exp_w) begin
                        merrs++;
                        $display("FAIL write act=%h:%h exp=%h:%h",
                                 mem_address, mem_write_data,
                                 exp_w[47:32], exp_w[31:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout act=stuck exp=accept");
                in_valid = 1'b0;
                return;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit stall,
                               input bit mid_start);
        for (int i = 0; i < s.size(); i++) begin
            if (mid_start && i == 6) pulse_start();
            send(s[i], stall ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic wait_done(input string n);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) break;
            k++;
            if (k > 40) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout act=no_done exp=done", n);
                return;
            end
        end
    endtask

    task automatic check_reset(input string n);
        chk({n, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({n, "_wen"}, 32'(mem_wEn), 32'd0);
        chk({n, "_addr"}, 32'(mem_address), 32'd0);
        chk({n, "_wdata"}, mem_write_data, 32'd0);
        chk({n, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({n, "_busy"}, 32'(busy), 32'd0);
        chk({n, "_done"}, 32'(done), 32'd0);
        chk({n, "_error"}, 32'(error), 32'd0);
        chk({n, "_wcount"}, 32'(word_count), 32'd0);
    endtask

    logic [7:0] two_w[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                             8'h93, 8'h05, 8'h40, 8'h00};
    logic [7:0] zero_w[$] = '{8'h00, 8'h00};
    logic [7:0] over_w[$] = '{8'h05, 8'h00};
    logic [7:0] one_w[$] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] part_w[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    logic [7:0] beef_w[$] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    initial begin
        int d0;
        rst      = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;

        // Reset asserted mid-cycle.
        #12 rst = 1'b0;
        #1 check_reset("rst");
        #10 rst = 1'b1;
        repeat (3) tick();
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        // Two-word back-to-back load.
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd1);
        sb.push_back({16'h0000, 32'h00A00513});
        sb.push_back({16'h0004, 32'h00400593});
        d0 = done_cnt;
        send_stream(two_w, 1'b0, 1'b0);
        @(negedge clk);
        chk("n1_wen", 32'(mem_wEn), 32'd1);
        chk("n1_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("n2_done", 32'(done), 32'd1);
        chk("n2_wcount", 32'(word_count), 32'd2);
        chk("n2_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        chk("n3_done", 32'(done), 32'd0);
        chk("n3_hold", 32'(cpu_hold), 32'd0);
        chk("n3_busy", 32'(busy), 32'd0);
        chk("two_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("two_sb_empty", 32'(sb.size()), 32'd0);

        // Same image with stalls and a stray start mid-load.
        tick();
        pulse_start();
        sb.push_back({16'h0000, 32'h00A00513});
        sb.push_back({16'h0004, 32'h00400593});
        d0 = done_cnt;
        send_stream(two_w, 1'b1, 1'b1);
        wait_done("stall");
        chk("stall_wcount", 32'(word_count), 32'd2);
        @(negedge clk);
        chk("stall_hold", 32'(cpu_hold), 32'd0);
        chk("stall_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-length image.
        tick();
        pulse_start();
        send_stream(zero_w, 1'b0, 1'b0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_wcount", 32'(word_count), 32'd0);
        @(negedge clk);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);

        // Overflow: 5 words exceeds MAX_WORDS=4.
        tick();
        pulse_start();
        d0 = done_cnt;
        send_stream(over_w, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_ready", 32'(in_ready), 32'd0);
        chk("ovf_hold", 32'(cpu_hold), 32'd1);
        repeat (3) tick();
        chk("ovf_hold_later", 32'(cpu_hold), 32'd1);
        chk("ovf_no_done", 32'(done_cnt - d0), 32'd0);
        pulse_start();
        chk("ovf_err_clear", 32'(error), 32'd0);
        sb.push_back({16'h0000, 32'h12345678});
        send_stream(one_w, 1'b0, 1'b0);
        wait_done("after_ovf");
        chk("after_ovf_wcount", 32'(word_count), 32'd1);
        chk("after_ovf_error", 32'(error), 32'd0);

        // Abort after the first word of a two-word image.
        repeat (2) tick();
        pulse_start();
        sb.push_back({16'h0000, 32'h00A00513});
        send_stream(part_w, 1'b0, 1'b0);
        @(negedge clk);
        chk("abort_wen", 32'(mem_wEn), 32'd1);
        tick();
        #2 rst = 1'b0;
        #1 check_reset("abort");
        tick();
        #2 rst = 1'b1;
        tick();
        chk("abort_ready", 32'(in_ready), 32'd0);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        pulse_start();
        sb.push_back({16'h0000, 32'hDEADBEEF});
        send_stream(beef_w, 1'b0, 1'b0);
        wait_done("restart");
        chk("restart_wcount", 32'(word_count), 32'd1);
        @(negedge clk);
        chk("restart_hold", 32'(cpu_hold), 32'd0);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

        repeat (3) tick();
        checks += mchecks;
        errors += merrs;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
